// File: rtl/d05200_otp_model.sv
// d05200_otp_model
// Cycle-accurate responder for a 128x8 one-time-programmable macro port.
// Stands in for the hard OTP macro so the controller sees real read latency,
// program-pulse timing, VPP gating and OR-only (0->1) programming.
//
// Ports:
//   CLK      model clock
//   RST      synchronous active-high reset (array contents are preserved)
//   VPP      programming voltage present
//   CS       chip select
//   READ     read request (level)
//   PROG     program request (level)
//   ADR      word address
//   DIN      program data
//   DO       registered read data
//   BUSY     high whenever the model is not idle
//   PROG_OK  one-cycle pulse when a word has been committed
//   PROG_ERR one-cycle pulse on a rejected or aborted access
module d05200_otp_model #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 128,
    parameter int RD_LAT   = 3,
    parameter int PROG_CYC = 500,
    parameter logic [DATA_W-1:0] BLANK = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VPP,
    input  logic              CS,
    input  logic              READ,
    input  logic              PROG,
    input  logic [ADDR_W-1:0] ADR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DO,
    output logic              BUSY,
    output logic              PROG_OK,
    output logic              PROG_ERR
);

    localparam int RC_W = $clog2(RD_LAT + 1);
    localparam int PC_W = $clog2(PROG_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_HOLD  = 3'd2,
        ST_PG_CNT   = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_e;

    // Addresses beyond DEPTH read as BLANK and refuse programming.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(DEPTH));
    endfunction

    // The array is never touched by RST; it only starts at BLANK.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: BLANK};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [RC_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [PC_W-1:0]   pg_cnt_q, pg_cnt_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic              busy_q;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              wr_en_s;
    logic              qual_s;

    // Next-state, datapath and pulse decode.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rd_cnt_d = rd_cnt_q;
        pg_cnt_d = pg_cnt_q;
        do_d     = do_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        wr_en_s  = 1'b0;
        qual_s   = CS & PROG & VPP & ~READ;

        case (state_q)
            ST_IDLE: begin
                if (!CS) begin
                    do_d = '0;
                end else if (READ && PROG) begin
                    // Simultaneous read and program is illegal: no array access.
                    err_d   = 1'b1;
                    state_d = ST_WAIT_REL;
                end else if (READ) begin
                    addr_d   = ADR;
                    rd_cnt_d = RC_W'(1);
                    state_d  = ST_RD_WAIT;
                end else if (PROG) begin
                    addr_d = ADR;
                    din_d  = DIN;
                    if (!VPP || !addr_in_range(ADR)) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_REL;
                    end else begin
                        // The sampling edge itself is qualified cycle 1.
                        pg_cnt_d = PC_W'(1);
                        state_d  = ST_PG_CNT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (!CS || !READ) begin
                    do_d    = '0;
                    state_d = ST_IDLE;
                end else if (rd_cnt_q == RC_W'(RD_LAT)) begin
                    do_d    = addr_in_range(addr_q) ? mem_q[addr_q] : BLANK;
                    state_d = ST_RD_HOLD;
                end else begin
                    rd_cnt_d = rd_cnt_q + RC_W'(1);
                end
            end
            ST_RD_HOLD: begin
                if (!CS) begin
                    do_d    = '0;
                    state_d = ST_IDLE;
                end else if (!READ) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_HOLD;
                end
            end
            ST_PG_CNT: begin
                if (!qual_s) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_REL;
                end else if (pg_cnt_q == PC_W'(PROG_CYC - 1)) begin
                    wr_en_s = 1'b1;
                    ok_d    = 1'b1;
                    state_d = ST_WAIT_REL;
                end else begin
                    pg_cnt_d = pg_cnt_q + PC_W'(1);
                end
            end
            ST_WAIT_REL: begin
                // Holding PROG or READ must not start another access.
                if (!PROG && !READ) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            din_q    <= '0;
            rd_cnt_q <= '0;
            pg_cnt_q <= '0;
            do_q     <= '0;
            busy_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rd_cnt_q <= rd_cnt_d;
            pg_cnt_q <= pg_cnt_d;
            do_q     <= do_d;
            busy_q   <= (state_d != ST_IDLE);
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    // OR-only array update; bits can be set but never cleared.
    always_ff @(posedge CLK) begin
        if (wr_en_s && !RST) begin
            mem_q[addr_q] <= mem_q[addr_q] | din_q;
        end
    end

    assign DO       = do_q;
    assign BUSY     = busy_q;
    assign PROG_OK  = ok_q;
    assign PROG_ERR = err_q;

endmodule

// File: tb/tb_d05200_otp_model.sv
// Directed bench for d05200_otp_model with hand-computed expectations.
module tb_d05200_otp_model;

    logic       CLK = 1'b0;
    logic       RST;
    logic       VPP;
    logic       CS;
    logic       READ;
    logic       PROG;
    logic [6:0] ADR;
    logic [7:0] DIN;
    logic [7:0] DO;
    logic       BUSY;
    logic       PROG_OK;
    logic       PROG_ERR;

    int n_cmp = 0;
    int n_err = 0;

    d05200_otp_model dut (
        .CLK      (CLK),
        .RST      (RST),
        .VPP      (VPP),
        .CS       (CS),
        .READ     (READ),
        .PROG     (PROG),
        .ADR      (ADR),
        .DIN      (DIN),
        .DO       (DO),
        .BUSY     (BUSY),
        .PROG_OK  (PROG_OK),
        .PROG_ERR (PROG_ERR)
    );

    // 100 MHz bench clock.
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full read: checks DO one cycle before and at the latency point,
    // ignores an ADR change in hold, then releases with CS kept high.
    task automatic read_chk(input string tag, input logic [6:0] a,
                            input logic [7:0] prev, input logic [7:0] exp);
        CS = 1'b1; READ = 1'b1; PROG = 1'b0; ADR = a;
        tick();                                   // edge k
        chk_eq({tag, "_busy"}, BUSY, 1'b1);
        tick();                                   // k+1
        tick();                                   // k+2
        chk_eq({tag, "_early"}, DO, prev);
        tick();                                   // k+3
        chk_eq({tag, "_data"}, DO, exp);
        ADR = a ^ 7'h01;
        tick();
        chk_eq({tag, "_hold"}, DO, exp);
        READ = 1'b0;
        tick();
        chk_eq({tag, "_rel_busy"}, BUSY, 1'b0);
        chk_eq({tag, "_rel_do"}, DO, exp);
    endtask

    // Qualified program lasting the full window, then release.
    task automatic prog_full(input string tag, input logic [6:0] a, input logic [7:0] d);
        logic early_ok;
        early_ok = 1'b0;
        CS = 1'b1; VPP = 1'b1; PROG = 1'b1; READ = 1'b0; ADR = a; DIN = d;
        tick();                                   // cycle 1
        for (int i = 2; i < 500; i++) begin
            tick();
            early_ok = early_ok | PROG_OK | PROG_ERR;
        end
        chk_eq({tag, "_no_early_pulse"}, early_ok, 1'b0);
        tick();                                   // cycle 500 commit edge
        chk_eq({tag, "_ok"}, PROG_OK, 1'b1);
        chk_eq({tag, "_no_err"}, PROG_ERR, 1'b0);
        PROG = 1'b0;
        tick();
        chk_eq({tag, "_ok_one_cycle"}, PROG_OK, 1'b0);
        chk_eq({tag, "_rel_busy"}, BUSY, 1'b0);
    endtask

    initial begin
        RST = 1'b1; VPP = 1'b0; CS = 1'b0; READ = 1'b0; PROG = 1'b0;
        ADR = 7'h00; DIN = 8'h00;

        // Reset state.
        tick();
        tick();
        chk_eq("rst_do", DO, 8'h00);
        chk_eq("rst_busy", BUSY, 1'b0);
        chk_eq("rst_ok", PROG_OK, 1'b0);
        chk_eq("rst_err", PROG_ERR, 1'b0);
        RST = 1'b0;
        tick();

        // Blank read.
        read_chk("blank", 7'h10, 8'h00, 8'h00);

        // Program and OR semantics.
        prog_full("pg_a5", 7'h10, 8'hA5);
        read_chk("rd_a5", 7'h10, 8'h00, 8'hA5);
        prog_full("pg_0f", 7'h10, 8'h0F);
        read_chk("rd_af", 7'h10, 8'hA5, 8'hAF);

        // VPP low at program start.
        VPP = 1'b0; PROG = 1'b1; DIN = 8'h50; ADR = 7'h10;
        tick();
        chk_eq("vpp0_err", PROG_ERR, 1'b1);
        chk_eq("vpp0_busy", BUSY, 1'b1);
        tick();
        chk_eq("vpp0_err_pulse", PROG_ERR, 1'b0);
        chk_eq("vpp0_waitrel", BUSY, 1'b1);
        PROG = 1'b0;
        tick();
        chk_eq("vpp0_idle", BUSY, 1'b0);
        read_chk("rd_vpp0", 7'h10, 8'hAF, 8'hAF);

        // VPP dropped at cycle 100.
        VPP = 1'b1; PROG = 1'b1; DIN = 8'h50; ADR = 7'h10;
        tick();
        for (int i = 2; i < 100; i++) tick();
        chk_eq("vppdrop_no_err_yet", PROG_ERR, 1'b0);
        VPP = 1'b0;
        tick();
        chk_eq("vppdrop_err", PROG_ERR, 1'b1);
        chk_eq("vppdrop_no_ok", PROG_OK, 1'b0);
        tick();
        chk_eq("vppdrop_waitrel", BUSY, 1'b1);
        tick();
        chk_eq("vppdrop_still_wait", BUSY, 1'b1);
        PROG = 1'b0;
        tick();
        chk_eq("vppdrop_idle", BUSY, 1'b0);
        read_chk("rd_vppdrop", 7'h10, 8'hAF, 8'hAF);

        // Illegal READ+PROG.
        VPP = 1'b1; READ = 1'b1; PROG = 1'b1; DIN = 8'h50;
        tick();
        chk_eq("illegal_err", PROG_ERR, 1'b1);
        chk_eq("illegal_do", DO, 8'hAF);
        READ = 1'b0; PROG = 1'b0;
        tick();
        chk_eq("illegal_idle", BUSY, 1'b0);
        read_chk("rd_illegal", 7'h10, 8'hAF, 8'hAF);

        // RST at program cycle 300.
        VPP = 1'b1; PROG = 1'b1; DIN = 8'h50; ADR = 7'h10;
        tick();
        for (int i = 2; i < 300; i++) tick();
        RST = 1'b1;
        tick();
        chk_eq("rstabort_busy", BUSY, 1'b0);
        chk_eq("rstabort_ok", PROG_OK, 1'b0);
        chk_eq("rstabort_do", DO, 8'h00);
        RST = 1'b0; PROG = 1'b0;
        tick();
        tick();
        chk_eq("rstabort_no_ok_later", PROG_OK, 1'b0);
        chk_eq("rstabort_idle", BUSY, 1'b0);
        read_chk("rd_after_rst", 7'h10, 8'h00, 8'hAF);

        // Other words stay blank.
        read_chk("rd_other", 7'h20, 8'hAF, 8'h00);
        read_chk("rd_af_again", 7'h10, 8'h00, 8'hAF);

        // CS dropped during RD_WAIT.
        CS = 1'b1; READ = 1'b1; ADR = 7'h10;
        tick();
        tick();
        chk_eq("csdrop_do_before", DO, 8'hAF);
        CS = 1'b0;
        tick();
        chk_eq("csdrop_do", DO, 8'h00);
        chk_eq("csdrop_idle", BUSY, 1'b0);
        READ = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
